// File: rtl/sqrt_seq_pkg.sv
// sqrt_seq_pkg: shared state encoding and sizing helper for the sequential square root.
package sqrt_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sqrtState;

    function automatic int cntWidth(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/sqrt_step.sv
// sqrt_step: one restoring digit-by-digit square-root iteration, purely combinational.
module sqrt_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH+1:0] remIn,
    input  logic [WIDTH-1:0] rootIn,
    input  logic [1:0]       radBits,
    output logic [WIDTH+1:0] remNext,
    output logic [WIDTH-1:0] rootNext
);

    logic [WIDTH+2:0] trial;
    logic [WIDTH+2:0] test;
    logic [WIDTH+1:0] diff;
    logic             fits;

    // rem never exceeds 2*root, so its top bit is zero; it still forces a subtract if ever set
    always_comb begin
        trial    = {remIn[WIDTH:0], radBits};
        test     = {1'b0, rootIn, 2'b01};
        diff     = trial[WIDTH+1:0] - test[WIDTH+1:0];
        fits     = remIn[WIDTH+1] || (trial >= test);
        remNext  = fits ? diff : trial[WIDTH+1:0];
        rootNext = {rootIn[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/sqrt_seq.sv
// sqrt_seq: sequential unsigned integer square root, one root bit per clock, valid/ready on both sides.
module sqrt_seq
    import sqrt_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inValid,
    output logic               inReady,
    input  logic [2*WIDTH-1:0] radicand,
    output logic               outValid,
    input  logic               outReady,
    output logic [WIDTH-1:0]   root,
    output logic [WIDTH:0]     remainder
);

    localparam int CW = cntWidth(WIDTH);

    sqrtState           state, nextState;
    logic [2*WIDTH-1:0] radReg;
    logic [WIDTH+1:0]   remReg, remStep;
    logic [WIDTH-1:0]   rootReg, rootStep;
    logic [CW-1:0]      cnt;

    sqrt_step #(.WIDTH(WIDTH)) step (
        .remIn   (remReg),
        .rootIn  (rootReg),
        .radBits (radReg[2*WIDTH-1 -: 2]),
        .remNext (remStep),
        .rootNext(rootStep)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = inValid ? CALC : IDLE;
            CALC:    nextState = (cnt == '0) ? DONE : CALC;
            DONE:    nextState = outReady ? IDLE : DONE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        inReady  = (state == IDLE);
        outValid = (state == DONE);
    end

    // result registers load only on the last iteration so they hold steady through DONE and IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            radReg    <= '0;
            remReg    <= '0;
            rootReg   <= '0;
            cnt       <= '0;
            root      <= '0;
            remainder <= '0;
        end else if (state == IDLE && inValid) begin
            radReg  <= radicand;
            remReg  <= '0;
            rootReg <= '0;
            cnt     <= CW'(WIDTH - 1);
        end else if (state == CALC) begin
            radReg  <= radReg << 2;
            remReg  <= remStep;
            rootReg <= rootStep;
            if (cnt == '0) begin
                root      <= rootStep;
                remainder <= remStep[WIDTH:0];
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sqrt_seq.sv
// tb_sqrt_seq: directed and swept stimulus for sqrt_seq; a monitor scores every output handshake against a queue.
module tb_sqrt_seq;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           inValid = 1'b0;
    logic           inReady;
    logic [2*W-1:0] radicand = '0;
    logic           outValid;
    logic           outReady = 1'b0;
    logic [W-1:0]   root;
    logic [W:0]     remainder;

    typedef struct {
        int rad;
        int r;
        int m;
    } sbItem;

    sbItem sbq[$];
    int    total = 0;
    int    bad = 0;
    bit    randStall = 1'b0;

    always #5 clk = ~clk;

    sqrt_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inValid  (inValid),
        .inReady  (inReady),
        .radicand (radicand),
        .outValid (outValid),
        .outReady (outReady),
        .root     (root),
        .remainder(remainder)
    );

    task automatic check(input string name, input longint act, input longint expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // present a radicand; the expected result is queued once the accepting edge is certain
    task automatic send(input int v, input int r, input int m);
        int n = 0;
        inValid  = 1'b1;
        radicand = v[2*W-1:0];
        while (!inReady && n < 200) begin
            tick();
            n++;
        end
        if (!inReady) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: radicand %0d never accepted", v);
        end else begin
            sbq.push_back('{v, r, m});
        end
        tick();
        inValid = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (!inReady && n < 100) begin
            tick();
            n++;
        end
        check(name, inReady, 1);
    endtask

    always @(negedge clk) begin
        sbItem e;
        if (rst_n && outValid && outReady) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got root=%0d rem=%0d, required no result", root, remainder);
            end else begin
                e = sbq.pop_front();
                check($sformatf("root(%0d)", e.rad), root, e.r);
                check($sformatf("rem(%0d)", e.rad), remainder, e.m);
                check($sformatf("identity(%0d)", e.rad), longint'(root) * longint'(root) + longint'(remainder), e.rad);
                check($sformatf("rem_bound(%0d)", e.rad), longint'(remainder <= 2 * {1'b0, root}), 1);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (randStall) outReady = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        repeat (3) tick();
        check("reset_inReady", inReady, 1);
        check("reset_outValid", outValid, 0);
        check("reset_root", root, 0);
        check("reset_rem", remainder, 0);
        rst_n = 1'b1;
        tick();

        outReady = 1'b1;
        send(144, 12, 0);
        repeat (7) tick();
        check("latency_edge7", outValid, 0);
        tick();
        check("latency_edge8", outValid, 1);
        waitIdle("idle_after_144");

        send(200, 14, 4);
        send(0, 0, 0);
        send(65535, 255, 510);
        waitIdle("idle_after_max");

        outReady = 1'b0;
        send(1000, 31, 39);
        seen = 0;
        while (!outValid && seen < 20) begin
            tick();
            seen++;
        end
        inValid  = 1'b1;
        radicand = 16'd1;
        for (int i = 0; i < 5; i++) begin
            check("stall_outValid", outValid, 1);
            check("stall_root", root, 31);
            check("stall_rem", remainder, 39);
            check("stall_inReady", inReady, 0);
            tick();
        end
        outReady = 1'b1;
        tick();
        check("post_handshake_inReady", inReady, 1);
        check("post_handshake_outValid", outValid, 0);
        sbq.push_back('{1, 1, 0});
        tick();
        inValid = 1'b0;
        waitIdle("idle_after_1");

        inValid  = 1'b1;
        radicand = 16'd50000;
        tick();
        inValid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midreset_inReady", inReady, 1);
        check("midreset_outValid", outValid, 0);
        check("midreset_root", root, 0);
        check("midreset_rem", remainder, 0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            tick();
            if (outValid) seen++;
        end
        check("no_out_after_reset", seen, 0);
        send(49, 7, 0);
        waitIdle("idle_after_49");

        send(81, 9, 0);
        tick();
        inValid  = 1'b1;
        radicand = 16'd9999;
        tick();
        tick();
        inValid = 1'b0;
        waitIdle("idle_after_81");
        repeat (15) tick();
        check("ignored_9999", sbq.size(), 0);
        check("ignored_9999_idle", outValid, 0);

        randStall = 1'b1;
        for (int v = 0; v < 65536; v += 37) begin
            int r;
            r = isqrt(v);
            send(v, r, v - r * r);
        end
        send(65535, 255, 510);
        randStall = 1'b0;
        outReady  = 1'b1;
        seen = 0;
        while (sbq.size() > 0 && seen < 200) begin
            tick();
            seen++;
        end
        check("drain", sbq.size(), 0);
        waitIdle("idle_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
